// File: rtl/poly_arpeggiator.sv
// poly_arpeggiator: steps through held keys (up/down/ping-pong/random) and drives one-hot voice gates.
// Define ARP_HOLD_EN to add the hold input and the latched key register.
module poly_arpeggiator #(
    parameter int          NUM_KEYS  = 8,
    parameter int          CNT_W     = 16,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                        Clk,
    input  logic                        Reset_n,
    input  logic                        enable,
    input  logic [1:0]                  mode,
    input  logic [NUM_KEYS-1:0]         keys,
    input  logic [CNT_W-1:0]            step_time,
    input  logic [CNT_W-1:0]            gate_len,
`ifdef ARP_HOLD_EN
    input  logic                        hold,
`endif
    output logic [NUM_KEYS-1:0]         gates,
    output logic                        step,
    output logic [$clog2(NUM_KEYS)-1:0] cur_idx
);

    localparam int IW = $clog2(NUM_KEYS);

    localparam logic [0:0] STATE_IDLE = 1'b0;
    localparam logic [0:0] STATE_RUN  = 1'b1;

    localparam logic [1:0] MODE_UP   = 2'b00;
    localparam logic [1:0] MODE_DOWN = 2'b01;
    localparam logic [1:0] MODE_PING = 2'b10;
    localparam logic [1:0] MODE_RAND = 2'b11;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // Circular search upward from 'from', that position included. Caller guarantees a set bit.
    function automatic logic [IW-1:0] circ_up(input logic [NUM_KEYS-1:0] set, input int from);
        logic [IW-1:0] res;
        logic [IW-1:0] pidx;
        int            pos;
        res = {IW{1'b0}};
        for (int k = NUM_KEYS - 1; k >= 0; k--) begin
            pos  = (from + k) % NUM_KEYS;
            pidx = pos[IW-1:0];
            if (set[pidx]) begin
                res = pidx;
            end
        end
        return res;
    endfunction

    // Circular search downward from 'from' (from >= NUM_KEYS-1 keeps the modulo non-negative).
    function automatic logic [IW-1:0] circ_down(input logic [NUM_KEYS-1:0] set, input int from);
        logic [IW-1:0] res;
        logic [IW-1:0] pidx;
        int            pos;
        res = {IW{1'b0}};
        for (int k = NUM_KEYS - 1; k >= 0; k--) begin
            pos  = (from - k) % NUM_KEYS;
            pidx = pos[IW-1:0];
            if (set[pidx]) begin
                res = pidx;
            end
        end
        return res;
    endfunction

    // Nearest set bit strictly above 'cur', no wrap; MSB of the result is the found flag.
    function automatic logic [IW:0] lin_up(input logic [NUM_KEYS-1:0] set, input int cur);
        logic [IW:0]   res;
        logic [IW-1:0] pidx;
        res = {(IW + 1){1'b0}};
        for (int p = NUM_KEYS - 1; p >= 0; p--) begin
            pidx = p[IW-1:0];
            if ((p > cur) && set[pidx]) begin
                res = {1'b1, pidx};
            end
        end
        return res;
    endfunction

    // Nearest set bit strictly below 'cur', no wrap; MSB of the result is the found flag.
    function automatic logic [IW:0] lin_down(input logic [NUM_KEYS-1:0] set, input int cur);
        logic [IW:0]   res;
        logic [IW-1:0] pidx;
        res = {(IW + 1){1'b0}};
        for (int p = 0; p < NUM_KEYS; p++) begin
            pidx = p[IW-1:0];
            if ((p < cur) && set[pidx]) begin
                res = {1'b1, pidx};
            end
        end
        return res;
    endfunction

    function automatic logic [NUM_KEYS-1:0] onehot(input logic [IW-1:0] idx);
        logic [NUM_KEYS-1:0] one;
        one = {{(NUM_KEYS - 1){1'b0}}, 1'b1};
        return one << idx;
    endfunction

    // Fibonacci LFSR, taps x^16+x^14+x^13+x^11.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
    endfunction

    logic [0:0]          state_r,   state_nx_s;
    logic [CNT_W-1:0]    cnt_r,     cnt_nx_s;
    logic                dir_r,     dir_nx_s;
    logic [15:0]         lfsr_r,    lfsr_nx_s;
    logic [IW-1:0]       cur_idx_r, idx_nx_s;
    logic                start_r,   start_nx_s;
    logic [NUM_KEYS-1:0] gates_r,   gates_nx_s;
    logic                step_r,    step_nx_s;

    logic [NUM_KEYS-1:0] active_s;
    logic                any_s;
    logic [IW-1:0]       pick_s;
    logic                pick_dir_s;
    logic [IW:0]         fwd_s;
    logic [IW:0]         back_s;

`ifdef ARP_HOLD_EN
    logic [NUM_KEYS-1:0] lat_r;

    // Latch accumulates every pressed key while hold is asserted and clears otherwise.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            lat_r <= {NUM_KEYS{1'b0}};
        end else if (hold) begin
            lat_r <= lat_r | keys;
        end else begin
            lat_r <= {NUM_KEYS{1'b0}};
        end
    end

    // Active set comes from the latch under hold, from the live keys otherwise.
    always_comb begin
        if (hold) begin
            active_s = lat_r;
        end else begin
            active_s = keys;
        end
    end
`else
    // Active set is the live key vector.
    always_comb begin
        active_s = keys;
    end
`endif

    assign any_s = |active_s;

    // Choose the key the next step event lands on, and the ping-pong direction that goes with it.
    always_comb begin
        pick_s     = cur_idx_r;
        pick_dir_s = dir_r;
        fwd_s      = {(IW + 1){1'b0}};
        back_s     = {(IW + 1){1'b0}};
        case (mode)
            MODE_UP: begin
                if (start_r) begin
                    pick_s = circ_up(active_s, 0);
                end else begin
                    pick_s = circ_up(active_s, int'(cur_idx_r) + 1);
                end
            end
            MODE_DOWN: begin
                if (start_r) begin
                    pick_s = circ_down(active_s, NUM_KEYS - 1);
                end else begin
                    pick_s = circ_down(active_s, int'(cur_idx_r) + NUM_KEYS - 1);
                end
            end
            MODE_PING: begin
                if (dir_r == DIR_UP) begin
                    fwd_s  = lin_up(active_s, int'(cur_idx_r));
                    back_s = lin_down(active_s, int'(cur_idx_r));
                end else begin
                    fwd_s  = lin_down(active_s, int'(cur_idx_r));
                    back_s = lin_up(active_s, int'(cur_idx_r));
                end
                if (start_r) begin
                    pick_s     = circ_up(active_s, 0);
                    pick_dir_s = DIR_UP;
                end else if (fwd_s[IW]) begin
                    pick_s = fwd_s[IW-1:0];
                end else if (back_s[IW]) begin
                    // Ran off the end: bounce without repeating the endpoint.
                    pick_s     = back_s[IW-1:0];
                    pick_dir_s = ~dir_r;
                end else begin
                    pick_s = cur_idx_r;
                end
            end
            MODE_RAND: begin
                pick_s = circ_up(active_s, int'(lfsr_r[IW-1:0]) % NUM_KEYS);
            end
            default: begin
                pick_s = cur_idx_r;
            end
        endcase
    end

    // Sequencer next state: pass-through, idle wait, or stepping with the gate timer.
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        dir_nx_s   = dir_r;
        lfsr_nx_s  = lfsr_r;
        idx_nx_s   = cur_idx_r;
        start_nx_s = start_r;
        step_nx_s  = 1'b0;
        gates_nx_s = {NUM_KEYS{1'b0}};
        if (!enable) begin
            state_nx_s = STATE_IDLE;
            cnt_nx_s   = {CNT_W{1'b0}};
            dir_nx_s   = DIR_UP;
            start_nx_s = 1'b0;
            gates_nx_s = keys;
        end else if (state_r == STATE_IDLE) begin
            cnt_nx_s = {CNT_W{1'b0}};
            if (any_s) begin
                state_nx_s = STATE_RUN;
                start_nx_s = 1'b1;
            end else begin
                state_nx_s = STATE_IDLE;
                start_nx_s = 1'b0;
            end
        end else if (!any_s) begin
            state_nx_s = STATE_IDLE;
            cnt_nx_s   = {CNT_W{1'b0}};
            start_nx_s = 1'b0;
        end else begin
            // >= so a step_time lowered below cnt still wraps on the next cycle.
            if (start_r || (cnt_r >= step_time)) begin
                step_nx_s  = 1'b1;
                cnt_nx_s   = {CNT_W{1'b0}};
                idx_nx_s   = pick_s;
                dir_nx_s   = pick_dir_s;
                start_nx_s = 1'b0;
                if (mode == MODE_RAND) begin
                    lfsr_nx_s = lfsr_step(lfsr_r);
                end else begin
                    lfsr_nx_s = lfsr_r;
                end
            end else begin
                cnt_nx_s = cnt_r + {{(CNT_W - 1){1'b0}}, 1'b1};
            end
            gates_nx_s = onehot(idx_nx_s) & active_s & {NUM_KEYS{cnt_nx_s < gate_len}};
        end
    end

    // State and output registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r   <= STATE_IDLE;
            cnt_r     <= {CNT_W{1'b0}};
            dir_r     <= DIR_UP;
            lfsr_r    <= LFSR_SEED;
            cur_idx_r <= {IW{1'b0}};
            start_r   <= 1'b0;
            gates_r   <= {NUM_KEYS{1'b0}};
            step_r    <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            cnt_r     <= cnt_nx_s;
            dir_r     <= dir_nx_s;
            lfsr_r    <= lfsr_nx_s;
            cur_idx_r <= idx_nx_s;
            start_r   <= start_nx_s;
            gates_r   <= gates_nx_s;
            step_r    <= step_nx_s;
        end
    end

    assign gates   = gates_r;
    assign step    = step_r;
    assign cur_idx = cur_idx_r;

endmodule

// File: tb/tb_poly_arpeggiator.sv
// Testbench for poly_arpeggiator: cycle-by-cycle vector table plus hand sequences for reset, random and hold.
module tb_poly_arpeggiator;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        enable;
    logic [1:0]  mode;
    logic [7:0]  keys;
    logic [15:0] step_time;
    logic [15:0] gate_len;
`ifdef ARP_HOLD_EN
    logic        hold;
`endif
    logic [7:0]  gates;
    logic        step;
    logic [2:0]  cur_idx;

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        logic        en;
        logic [1:0]  md;
        logic [7:0]  ky;
        logic [15:0] st;
        logic [15:0] gl;
        logic [7:0]  eg;
        logic        es;
        logic [2:0]  ei;
    } vec_t;

    vec_t vecs[$];

    poly_arpeggiator dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .enable    (enable),
        .mode      (mode),
        .keys      (keys),
        .step_time (step_time),
        .gate_len  (gate_len),
`ifdef ARP_HOLD_EN
        .hold      (hold),
`endif
        .gates     (gates),
        .step      (step),
        .cur_idx   (cur_idx)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic en, input logic [1:0] md, input logic [7:0] ky,
                       input logic [15:0] st, input logic [15:0] gl,
                       input logic [7:0] eg, input logic es, input logic [2:0] ei);
        vec_t v;
        v.en = en; v.md = md; v.ky = ky; v.st = st; v.gl = gl;
        v.eg = eg; v.es = es; v.ei = ei;
        vecs.push_back(v);
    endtask

    initial begin
        logic [15:0] lfsr_m;
        logic [2:0]  exp_idx;
        logic [7:0]  one8;

        Reset_n   = 1'b0;
        enable    = 1'b1;
        mode      = 2'd0;
        keys      = 8'h00;
        step_time = 16'd3;
        gate_len  = 16'd2;
`ifdef ARP_HOLD_EN
        hold      = 1'b0;
`endif
        one8      = 8'h01;

        repeat (2) @(posedge Clk);
        @(negedge Clk);
        chk("reset_gates", {24'd0, gates}, 32'h0);
        chk("reset_step", {31'd0, step}, 32'h0);
        chk("reset_idx", {29'd0, cur_idx}, 32'h0);
        Reset_n = 1'b1;

        // Idle with nothing held
        repeat (3) add(1'b1, 2'd0, 8'h00, 16'd3, 16'd2, 8'h00, 1'b0, 3'd0);
        // Up, step_time=3, gate_len=2, keys 0,2,5
        add(1'b1, 2'd0, 8'h25, 16'd3, 16'd2, 8'h00, 1'b0, 3'd0);
        add(1'b1, 2'd0, 8'h25, 16'd3, 16'd2, 8'h01, 1'b1, 3'd0);
        add(1'b1, 2'd0, 8'h25, 16'd3, 16'd2, 8'h01, 1'b0, 3'd0);
        add(1'b1, 2'd0, 8'h25, 16'd3, 16'd2, 8'h00, 1'b0, 3'd0);
        add(1'b1, 2'd0, 8'h25, 16'd3, 16'd2, 8'h00, 1'b0, 3'd0);
        add(1'b1, 2'd0, 8'h25, 16'd3, 16'd2, 8'h04, 1'b1, 3'd2);
        add(1'b1, 2'd0, 8'h25, 16'd3, 16'd2, 8'h04, 1'b0, 3'd2);
        add(1'b1, 2'd0, 8'h25, 16'd3, 16'd2, 8'h00, 1'b0, 3'd2);
        add(1'b1, 2'd0, 8'h25, 16'd3, 16'd2, 8'h00, 1'b0, 3'd2);
        add(1'b1, 2'd0, 8'h25, 16'd3, 16'd2, 8'h20, 1'b1, 3'd5);
        add(1'b1, 2'd0, 8'h25, 16'd3, 16'd2, 8'h20, 1'b0, 3'd5);
        add(1'b1, 2'd0, 8'h25, 16'd3, 16'd2, 8'h00, 1'b0, 3'd5);
        add(1'b1, 2'd0, 8'h25, 16'd3, 16'd2, 8'h00, 1'b0, 3'd5);
        add(1'b1, 2'd0, 8'h25, 16'd3, 16'd2, 8'h01, 1'b1, 3'd0);
        // Pass-through, then down with step_time=0 alternating 7,0
        add(1'b0, 2'd1, 8'h81, 16'd0, 16'd1, 8'h81, 1'b0, 3'd0);
        add(1'b0, 2'd1, 8'h01, 16'd0, 16'd1, 8'h01, 1'b0, 3'd0);
        add(1'b0, 2'd1, 8'h81, 16'd0, 16'd1, 8'h81, 1'b0, 3'd0);
        add(1'b1, 2'd1, 8'h81, 16'd0, 16'd1, 8'h00, 1'b0, 3'd0);
        add(1'b1, 2'd1, 8'h81, 16'd0, 16'd1, 8'h80, 1'b1, 3'd7);
        add(1'b1, 2'd1, 8'h81, 16'd0, 16'd1, 8'h01, 1'b1, 3'd0);
        add(1'b1, 2'd1, 8'h81, 16'd0, 16'd1, 8'h80, 1'b1, 3'd7);
        add(1'b1, 2'd1, 8'h81, 16'd0, 16'd1, 8'h01, 1'b1, 3'd0);
        // All released while running: back to idle
        add(1'b1, 2'd1, 8'h00, 16'd0, 16'd1, 8'h00, 1'b0, 3'd0);
        // Ping-pong over keys 0,3,7
        add(1'b1, 2'd2, 8'h89, 16'd0, 16'd1, 8'h00, 1'b0, 3'd0);
        add(1'b1, 2'd2, 8'h89, 16'd0, 16'd1, 8'h01, 1'b1, 3'd0);
        add(1'b1, 2'd2, 8'h89, 16'd0, 16'd1, 8'h08, 1'b1, 3'd3);
        add(1'b1, 2'd2, 8'h89, 16'd0, 16'd1, 8'h80, 1'b1, 3'd7);
        add(1'b1, 2'd2, 8'h89, 16'd0, 16'd1, 8'h08, 1'b1, 3'd3);
        add(1'b1, 2'd2, 8'h89, 16'd0, 16'd1, 8'h01, 1'b1, 3'd0);
        add(1'b1, 2'd2, 8'h89, 16'd0, 16'd1, 8'h08, 1'b1, 3'd3);
        // Single held key repeats
        add(1'b1, 2'd2, 8'h08, 16'd0, 16'd1, 8'h08, 1'b1, 3'd3);
        add(1'b1, 2'd2, 8'h08, 16'd0, 16'd1, 8'h08, 1'b1, 3'd3);
        // gate_len=0 is silent but still steps
        add(1'b1, 2'd2, 8'h08, 16'd0, 16'd0, 8'h00, 1'b1, 3'd3);
        // gate_len > step_time: legato
        add(1'b1, 2'd0, 8'h08, 16'd1, 16'd5, 8'h08, 1'b0, 3'd3);
        add(1'b1, 2'd0, 8'h08, 16'd1, 16'd5, 8'h08, 1'b1, 3'd3);
        // Current key released: gate drops, search still starts from 3
        add(1'b1, 2'd0, 8'h25, 16'd10, 16'd20, 8'h00, 1'b0, 3'd3);
        add(1'b1, 2'd0, 8'h25, 16'd10, 16'd20, 8'h00, 1'b0, 3'd3);
        add(1'b1, 2'd0, 8'h25, 16'd10, 16'd20, 8'h00, 1'b0, 3'd3);
        // step_time lowered below cnt: step on the next edge
        add(1'b1, 2'd0, 8'h25, 16'd2, 16'd20, 8'h20, 1'b1, 3'd5);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge Clk);
            enable    = vecs[i].en;
            mode      = vecs[i].md;
            keys      = vecs[i].ky;
            step_time = vecs[i].st;
            gate_len  = vecs[i].gl;
            @(posedge Clk);
            #1;
            chk($sformatf("vec%0d_gates", i), {24'd0, gates}, {24'd0, vecs[i].eg});
            chk($sformatf("vec%0d_step", i), {31'd0, step}, {31'd0, vecs[i].es});
            chk($sformatf("vec%0d_idx", i), {29'd0, cur_idx}, {29'd0, vecs[i].ei});
        end

        // Asynchronous reset in the middle of a gate
        @(negedge Clk);
        @(posedge Clk);
        #1;
        chk("pre_reset_gates", {24'd0, gates}, 32'h20);
        #1;
        Reset_n = 1'b0;
        #1;
        chk("async_reset_gates", {24'd0, gates}, 32'h0);
        chk("async_reset_step", {31'd0, step}, 32'h0);
        chk("async_reset_idx", {29'd0, cur_idx}, 32'h0);

        // Random mode, all keys held, against a golden LFSR from the seed
        mode      = 2'd3;
        keys      = 8'hFF;
        step_time = 16'd0;
        gate_len  = 16'd1;
        enable    = 1'b1;
        @(negedge Clk);
        Reset_n = 1'b1;
        @(posedge Clk);
        #1;
        chk("rand_entry_step", {31'd0, step}, 32'h0);
        chk("rand_entry_gates", {24'd0, gates}, 32'h0);
        lfsr_m = 16'hACE1;
        for (int s = 0; s < 64; s++) begin
            @(posedge Clk);
            #1;
            exp_idx = lfsr_m[2:0];
            chk($sformatf("rand%0d_idx", s), {29'd0, cur_idx}, {29'd0, exp_idx});
            chk($sformatf("rand%0d_step", s), {31'd0, step}, 32'h1);
            chk($sformatf("rand%0d_gates", s), {24'd0, gates}, {24'd0, one8 << exp_idx});
            lfsr_m = {lfsr_m[0] ^ lfsr_m[2] ^ lfsr_m[3] ^ lfsr_m[5], lfsr_m[15:1]};
        end

`ifdef ARP_HOLD_EN
        // Hold: key 1 pressed and released, key 4 pressed, arpeggio over both
        @(negedge Clk);
        keys = 8'h00; mode = 2'd0; step_time = 16'd0; gate_len = 16'd1;
        @(negedge Clk);
        hold = 1'b1; keys = 8'h02;
        @(negedge Clk);
        keys = 8'h00;
        @(negedge Clk);
        keys = 8'h10;
        @(posedge Clk);
        #1;
        chk("hold_idx_a", {29'd0, cur_idx}, 32'h1);
        @(negedge Clk);
        keys = 8'h00;
        for (int h = 0; h < 3; h++) begin
            @(posedge Clk);
            #1;
            chk($sformatf("hold_idx_%0d", h), {29'd0, cur_idx}, (h % 2 == 0) ? 32'h4 : 32'h1);
        end
        @(negedge Clk);
        hold = 1'b0;
        @(posedge Clk);
        #1;
        chk("hold_off_gates", {24'd0, gates}, 32'h0);
        chk("hold_off_step", {31'd0, step}, 32'h0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/poly_arpeggiator.md
Name: poly_arpeggiator

Overview:
- Parametrised successor to the fixed 8-key ping-pong arpeggiator.
- Takes a held-key vector of NUM_KEYS bits, sequences through the held keys in one of four modes, and drives one-hot key_on gates to the voice bank.
- Adds a programmable gate length and an LFSR random mode.
- Runs on the sample-rate clock (AUD_DACLRCK domain), between the soc key registers and the Voice instances.

Parameters:
- NUM_KEYS, 8, number of key inputs and gate outputs; legal range 2..32.
- CNT_W, 16, width of the step and gate timers.
- LFSR_SEED, 16'hACE1, reset value of the 16-bit random LFSR; must be non-zero.

Ports:
- Clk  in  1  sample-rate clock; all logic on rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  1 = arpeggiate; 0 = pass-through.
- mode  in  2  00 up, 01 down, 10 ping-pong, 11 random.
- keys  in  NUM_KEYS  held keys; bit i = key i.
- step_time  in  CNT_W  step period minus 1, in Clk cycles.
- gate_len  in  CNT_W  gate-high cycles per step.
- gates  out  NUM_KEYS  key_on outputs to the voices.
- step  out  1  single-cycle pulse on each step event.
- cur_idx  out  $clog2(NUM_KEYS)  index of the current key.

Behaviour:
- Reset values: gates=0, step=0, cur_idx=0, cnt=0, dir=up, lfsr=LFSR_SEED, state=IDLE.
- Pass-through (enable=0):
  - gates <= keys, one-cycle latency.
  - cnt, dir and state are forced to their reset values; cur_idx is held.
- States: IDLE, RUN.
- IDLE (enable=1, active set empty):
  - gates=0, cnt=0.
  - When the active set becomes non-empty, go to RUN. On the next edge, take a step event to the start key: lowest set bit for up/ping-pong, highest for down, LFSR pick for random.
- RUN:
  - cnt increments each cycle.
  - When cnt==step_time: cnt<=0, step event, advance to the next key.
  - If the active set becomes empty: go to IDLE, gates<=0 on the next edge.
- Active set: keys (see Optional Feature).
- Step event: step=1 for that cycle; cur_idx updates on the same edge.
- Next-key selection is a circular search over the active set from cur_idx, excluding cur_idx unless it is the only set bit:
  - up: next higher set bit, wrapping to the lowest.
  - down: next lower set bit, wrapping to the highest.
  - ping-pong: search in the dir direction. If none is found before the array end, flip dir and search the other way. Endpoints are not repeated. A single held key repeats.
  - random: lfsr shifts each step (x^16+x^14+x^13+x^11). Start the circular up-search at lfsr[IW-1:0] mod NUM_KEYS, including that position.
- Released key: if the key at cur_idx is released mid-step, its gate drops on the next edge. The next search still starts from cur_idx.
- Gate output:
  - gates = onehot(cur_idx) & active & {NUM_KEYS{cnt < gate_len}}.
  - gate_len=0 gives silence.
  - gate_len > step_time gives legato (gate never drops between steps).
- step_time=0 gives a step every cycle.
- Register changes: step_time reduced below cnt takes effect at the next cnt wrap via a >= compare (cnt>=step_time triggers the step). mode changes take effect at the next step.
- enable 1->0 mid-step: pass-through on the next edge. 0->1: IDLE/RUN entry as above.
- Async reset mid-step: all outputs go to their reset values immediately.

Optional Feature:
- Macro: ARP_HOLD_EN.
- When defined:
  - Adds input port hold (1 bit) and a latched register lat (NUM_KEYS).
  - With hold=1: lat <= lat | keys, and active = lat.
  - With hold=0: lat <= 0, and active = keys.
  - Pressing keys after all keys were released while hold=1 keeps accumulating into lat.
- When undefined: no hold port, no lat register; active = keys.

Test Plan:
- Reset, keys=8'h00, enable=1: gates=0, step never pulses, cur_idx=0.
- mode=up, step_time=3, gate_len=2, keys=8'b0010_0101: cur_idx sequence 0,2,5,0 every 4 cycles; each gate is high 2 cycles then low 2.
- mode=ping-pong, keys=8'b1000_1001: cur_idx sequence 0,3,7,3,0,3; a single held key repeats the same index every step.
- mode=down, step_time=0, gate_len=1, keys=8'h81, enable=0 then 1: pass-through gates=8'h81 one cycle after keys; after enable, cur_idx alternates 7,0 every cycle.
- Random, keys=8'hFF, 64 steps: every cur_idx is a held key; the sequence matches the golden LFSR model from LFSR_SEED.
- ARP_HOLD_EN, hold=1, press key 1 then release, press key 4: active=8'h12 and the arpeggio alternates 1,4. hold=0: gates=0 next cycle, state IDLE.
